// File: rtl/text_line_display_pkg.sv
// Shared widths, constants and pipeline payload for the text line overlay.
package text_line_display_pkg;

  localparam int unsigned GLYPH_W = 8;
  localparam int unsigned GLYPH_H = 8;
  localparam int unsigned ROM_AW  = 9;
  localparam int unsigned CODE_W  = 6;
  localparam int unsigned VGA_XW  = 11;
  localparam int unsigned VGA_YW  = 10;
  localparam int unsigned COLOR_W = 24;
  localparam int unsigned DIFF_W  = VGA_XW + 1;

  localparam logic [CODE_W-1:0] CODE_SPACE = 6'd32;

  // Stage-1 to stage-2 payload travelling alongside the ROM address.
  typedef struct packed {
    logic               hit;
    logic               blank;
    logic               invert;
    logic [2:0]         col;
    logic [COLOR_W-1:0] color;
  } s1_t;

endpackage

// File: rtl/text_line_display_tcgrom.sv
// Glyph ROM stand-in: address {code, row} -> 8 pixel row, MSB is the leftmost column.
module tcgrom
  import text_line_display_pkg::*;
(
  input  logic [ROM_AW-1:0]  i_addr,
  output logic [GLYPH_W-1:0] o_data_c
);

  logic [CODE_W-1:0] w_code;
  logic [2:0]        w_row;
  logic [63:0]       w_glyph;

  assign w_code = i_addr[ROM_AW-1:3];
  assign w_row  = i_addr[2:0];

  // Codes without a drawn glyph show a hollow box so they are visible on screen.
  always_comb begin
    w_glyph = 64'hFF81_8181_8181_81FF;
    case (w_code)
      6'd0:    w_glyph = 64'h3C66_6E6E_6062_3C00;
      6'd1:    w_glyph = 64'h183C_667E_6666_6600;
      6'd2:    w_glyph = 64'h7C66_667C_6666_7C00;
      6'd3:    w_glyph = 64'h3C66_6060_6066_3C00;
      6'd32:   w_glyph = 64'h0000_0000_0000_0000;
      default: w_glyph = 64'hFF81_8181_8181_81FF;
    endcase
  end

  assign o_data_c = w_glyph[{~w_row, 3'b000} +: GLYPH_W];

endmodule

// File: rtl/text_line_display.sv
// One line of scaled 8x8 glyphs with frame-synchronous double buffering,
// blink and reverse video; two-stage pixel pipeline into an OR-merged overlay.
module text_line_display
  import text_line_display_pkg::*;
#(
  parameter int unsigned NUM_CHARS    = 8,
  parameter int unsigned SCALE_LOG2   = 1,
  parameter int unsigned BLINK_FRAMES = 30,
  localparam int unsigned IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [CODE_W-1:0]  wr_code,
  input  logic [VGA_XW-1:0]  origin_x,
  input  logic [VGA_YW-1:0]  origin_y,
  input  logic               blink_en,
  input  logic               invert,
  input  logic [COLOR_W-1:0] color,
  input  logic [VGA_XW-1:0]  vga_x,
  input  logic [VGA_YW-1:0]  vga_y,
  input  logic               valid,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic               valid_px
);

  localparam int unsigned IDXE_W     = IDX_W + 1;
  localparam int unsigned CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned CELL_SHIFT = 3 + SCALE_LOG2;
  localparam int unsigned LINE_W     = NUM_CHARS << CELL_SHIFT;
  localparam int unsigned CELL_H     = GLYPH_H << SCALE_LOG2;

  logic [CODE_W-1:0]  r_shadow [NUM_CHARS];
  logic [CODE_W-1:0]  r_active [NUM_CHARS];
  logic [VGA_XW-1:0]  r_org_x;
  logic [VGA_YW-1:0]  r_org_y;
  logic [CNT_W-1:0]   r_blink_cnt;
  logic               r_blink_phase;
  s1_t                r_s1;
  logic [ROM_AW-1:0]  r_rom_addr;
  logic               r_valid_px;
  logic [COLOR_W-1:0] r_rgb;

  logic [DIFF_W-1:0]  w_dx;
  logic [DIFF_W-1:0]  w_dy;
  logic [DIFF_W-1:0]  w_cell;
  logic [CODE_W-1:0]  w_code;
  logic [2:0]         w_row;
  s1_t                w_s1;
  logic [GLYPH_W-1:0] w_rom_data;
  logic               w_bit;
  logic               w_px;

  // Shadow text: out-of-range slots are dropped rather than wrapped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CHARS; i++) r_shadow[i] <= CODE_SPACE;
    end else if (wr_en && ({1'b0, wr_idx} < IDXE_W'(NUM_CHARS))) begin
      r_shadow[wr_idx] <= wr_code;
    end
  end

  // Active text and origin only change at frame start, so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CHARS; i++) r_active[i] <= CODE_SPACE;
      r_org_x <= '0;
      r_org_y <= '0;
    end else if (frame_start) begin
      for (int unsigned i = 0; i < NUM_CHARS; i++) r_active[i] <= r_shadow[i];
      r_org_x <= origin_x;
      r_org_y <= origin_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1: position relative to origin; negative offsets have the top bit set.
  assign w_dx   = {1'b0, vga_x} - {1'b0, r_org_x};
  assign w_dy   = {2'b00, vga_y} - {2'b00, r_org_y};
  assign w_cell = w_dx >> CELL_SHIFT;
  assign w_row  = 3'(w_dy >> SCALE_LOG2);
  assign w_code = (w_cell < DIFF_W'(NUM_CHARS)) ? r_active[w_cell[IDX_W-1:0]] : CODE_SPACE;

  always_comb begin
    w_s1        = '0;
    w_s1.hit    = valid & ~w_dx[DIFF_W-1] & ~w_dy[DIFF_W-1]
                & (w_dx < DIFF_W'(LINE_W)) & (w_dy < DIFF_W'(CELL_H));
    w_s1.blank  = blink_en & r_blink_phase;
    w_s1.invert = invert;
    w_s1.col    = 3'(w_dx >> SCALE_LOG2);
    w_s1.color  = color;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1       <= '0;
      r_rom_addr <= '0;
    end else begin
      r_s1       <= w_s1;
      r_rom_addr <= {w_code, w_row};
    end
  end

  tcgrom u_rom (
    .i_addr   (r_rom_addr),
    .o_data_c (w_rom_data)
  );

  // Stage 2: ROM read, reverse video and blink gate resolved into the output flops.
  assign w_bit = w_rom_data[~r_s1.col];
  assign w_px  = r_s1.hit & (w_bit ^ r_s1.invert) & ~r_s1.blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_px <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_valid_px <= w_px;
      r_rgb      <= w_px ? r_s1.color : '0;
    end
  end

  assign valid_px = r_valid_px;
  assign r        = r_rgb[23:16];
  assign g        = r_rgb[15:8];
  assign b        = r_rgb[7:0];

endmodule

// File: tb/tb_text_line_display.sv
// Randomised bench for text_line_display against a pixel-level reference model.
module tb_text_line_display;

  localparam int NC   = 6;
  localparam int SL   = 1;
  localparam int BF   = 2;
  localparam int CELL = 8 << SL;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [5:0]  wr_code;
  logic [10:0] origin_x;
  logic [9:0]  origin_y;
  logic        blink_en;
  logic        invert;
  logic [23:0] color;
  logic [10:0] vga_x;
  logic [9:0]  vga_y;
  logic        valid;
  logic [7:0]  r, g, b;
  logic        valid_px;

  int errors;
  int checks;
  int m_shadow [NC];
  int m_active [NC];
  int m_ox, m_oy, m_fs;
  logic [24:0] m_pipe1, m_exp;
  logic [24:0] got;
  int codes [6] = '{0, 1, 2, 3, 32, 9};

  text_line_display #(.NUM_CHARS(NC), .SCALE_LOG2(SL), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_code(wr_code), .origin_x(origin_x), .origin_y(origin_y),
    .blink_en(blink_en), .invert(invert), .color(color), .vga_x(vga_x),
    .vga_y(vga_y), .valid(valid), .r(r), .g(g), .b(b), .valid_px(valid_px)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] font(int code, int row);
    logic [63:0] gl;
    case (code)
      0:       gl = 64'h3C666E6E60623C00;
      1:       gl = 64'h183C667E66666600;
      2:       gl = 64'h7C66667C66667C00;
      3:       gl = 64'h3C66606060663C00;
      32:      gl = 64'h0;
      default: gl = 64'hFF818181818181FF;
    endcase
    return gl[(7-row)*8 +: 8];
  endfunction

  // Expected output for the inputs currently driven, from the model's frame state.
  function automatic logic [24:0] ref_pixel();
    int dx, dy, col, row, lit;
    logic [7:0] fr;
    bit blank;
    dx = int'(vga_x) - m_ox;
    dy = int'(vga_y) - m_oy;
    if (!valid || dx < 0 || dy < 0 || dx >= NC*CELL || dy >= CELL) return 25'd0;
    col = (dx % CELL) / (CELL/8);
    row = (dy % CELL) / (CELL/8);
    fr  = font(m_active[dx / CELL], row);
    lit = int'(fr[7-col]) ^ int'(invert);
    blank = blink_en && ((m_fs / BF) % 2 == 1);
    if (lit != 0 && !blank) return {1'b1, color};
    return 25'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin m_shadow[i] = 32; m_active[i] = 32; end
    m_ox = 0; m_oy = 0; m_fs = 0; m_pipe1 = '0; m_exp = '0;
  endtask

  // One clock: advance DUT and model, leaving m_exp as the output now due.
  task automatic cycle();
    logic [24:0] e;
    e = ref_pixel();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_exp = m_pipe1;
      m_pipe1 = e;
      if (frame_start) begin
        for (int i = 0; i < NC; i++) m_active[i] = m_shadow[i];
        m_ox = int'(origin_x); m_oy = int'(origin_y); m_fs++;
      end
      if (wr_en && int'(wr_idx) < NC) m_shadow[wr_idx] = int'(wr_code);
    end
    #1;
    got = {valid_px, r, g, b};
  endtask

  task automatic do_write(int idx, int code);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_code = 6'(code); valid = 1'b0;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic do_frame(int ox, int oy);
    origin_x = 11'(ox); origin_y = 10'(oy); frame_start = 1'b1; valid = 1'b0;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      cycle();
      checks++;
      if (got !== 25'd0) begin errors++; $display("FAIL reset_out got=%h exp=0", got); end
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (got !== 25'd0) begin errors++; $display("FAIL post_reset_out got=%h exp=0", got); end
  endtask

  task automatic test_blank_scan();
    int lit;
    lit = 0;
    do_frame(0, 0);
    for (int y = 0; y < 480; y += 24) begin
      for (int x = 0; x < 640; x++) begin
        vga_x = 11'(x); vga_y = 10'(y); valid = 1'b1; color = $urandom;
        cycle();
        lit += int'(valid_px);
        checks++;
        if (got !== m_exp) begin errors++; $display("FAIL blank_scan y=%0d x=%0d got=%h exp=%h", y, x, got, m_exp); end
      end
    end
    checks++;
    if (lit !== 0) begin errors++; $display("FAIL blank_lit_count got=%0d exp=0", lit); end
  endtask

  task automatic test_glyph_a();
    int lit;
    lit = 0;
    do_write(0, 1);
    do_frame(100, 50);
    color = 24'hFF8000;
    for (int y = 44; y <= 70; y++) begin
      for (int x = 92; x <= 124; x++) begin
        vga_x = 11'(x); vga_y = 10'(y); valid = 1'b1;
        cycle();
        lit += int'(valid_px);
        checks++;
        if (got !== m_exp) begin errors++; $display("FAIL glyph_a y=%0d x=%0d got=%h exp=%h", y, x, got, m_exp); end
      end
    end
    checks++;
    if (lit !== 112) begin errors++; $display("FAIL glyph_a_lit_count got=%0d exp=112", lit); end
    // Single lit pixel (row 0, column 3) must appear exactly two clocks later.
    valid = 1'b0;
    repeat (3) cycle();
    vga_x = 11'd106; vga_y = 10'd50; valid = 1'b1; color = 24'h123456;
    cycle();
    valid = 1'b0;
    checks++;
    if (got !== 25'd0) begin errors++; $display("FAIL latency_1clk got=%h exp=0", got); end
    cycle();
    checks++;
    if (got !== {1'b1, 24'h123456}) begin errors++; $display("FAIL latency_2clk got=%h exp=1123456", got); end
    cycle();
    checks++;
    if (got !== 25'd0) begin errors++; $display("FAIL latency_3clk got=%h exp=0", got); end
  endtask

  task automatic test_same_cycle_write();
    int lit;
    for (int pass = 0; pass < 2; pass++) begin
      lit = 0;
      if (pass == 0) begin
        wr_en = 1'b1; wr_idx = 3'd2; wr_code = 6'd2;
      end
      do_frame(100, 50);
      wr_en = 1'b0;
      for (int y = 50; y < 66; y++) begin
        for (int x = 132; x < 148; x++) begin
          vga_x = 11'(x); vga_y = 10'(y); valid = 1'b1; color = $urandom;
          cycle();
          lit += int'(valid_px);
          checks++;
          if (got !== m_exp) begin errors++; $display("FAIL same_cycle_wr pass=%0d got=%h exp=%h", pass, got, m_exp); end
        end
      end
      valid = 1'b0;
      repeat (2) begin cycle(); lit += int'(valid_px); end
      checks++;
      if (lit !== ((pass == 0) ? 0 : 124)) begin
        errors++; $display("FAIL same_cycle_lit pass=%0d got=%0d exp=%0d", pass, lit, (pass == 0) ? 0 : 124);
      end
    end
  endtask

  task automatic test_bad_idx_edge();
    int lit;
    do_write(6, 3);
    do_write(7, 3);
    do_frame(100, 50);
    lit = 0;
    for (int y = 50; y < 66; y++) begin
      for (int x = 96; x <= 200; x++) begin
        vga_x = 11'(x); vga_y = 10'(y); valid = 1'b1; color = $urandom;
        cycle();
        lit += int'(valid_px);
        checks++;
        if (got !== m_exp) begin errors++; $display("FAIL bad_idx y=%0d x=%0d got=%h exp=%h", y, x, got, m_exp); end
      end
    end
    valid = 1'b0;
    repeat (2) begin cycle(); lit += int'(valid_px); end
    checks++;
    if (lit !== 236) begin errors++; $display("FAIL bad_idx_lit_count got=%0d exp=236", lit); end
    do_frame(2040, 200);
    lit = 0;
    for (int y = 198; y < 218; y++) begin
      for (int x = 2030; x < 2048; x++) begin
        vga_x = 11'(x); vga_y = 10'(y); valid = 1'b1; color = $urandom;
        cycle();
        lit += int'(valid_px);
        checks++;
        if (got !== m_exp) begin errors++; $display("FAIL edge_clip y=%0d x=%0d got=%h exp=%h", y, x, got, m_exp); end
      end
      for (int x = 0; x <= 20; x++) begin
        vga_x = 11'(x); vga_y = 10'(y); valid = 1'b1;
        cycle();
        lit += int'(valid_px);
        checks++;
        if (got !== m_exp) begin errors++; $display("FAIL edge_nowrap y=%0d x=%0d got=%h exp=%h", y, x, got, m_exp); end
      end
    end
    valid = 1'b0;
    repeat (2) begin cycle(); lit += int'(valid_px); end
    checks++;
    if (lit !== 56) begin errors++; $display("FAIL edge_lit_count got=%0d exp=56", lit); end
  endtask

  task automatic test_blink_invert();
    int lit, expv;
    bit vis;
    blink_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      invert = (f >= 4);
      do_frame(10, 10);
      vis = ((m_fs / BF) % 2 == 0);
      lit = 0;
      for (int y = 10; y < 26; y++) begin
        for (int x = 10; x < 42; x++) begin
          vga_x = 11'(x); vga_y = 10'(y); valid = 1'b1; color = $urandom;
          cycle();
          lit += int'(valid_px);
          checks++;
          if (got !== m_exp) begin errors++; $display("FAIL blink f=%0d y=%0d x=%0d got=%h exp=%h", f, y, x, got, m_exp); end
        end
      end
      valid = 1'b0;
      repeat (2) begin cycle(); lit += int'(valid_px); end
      expv = vis ? (invert ? 400 : 112) : 0;
      checks++;
      if (lit !== expv) begin errors++; $display("FAIL blink_lit_count f=%0d got=%0d exp=%0d", f, lit, expv); end
    end
    invert = 1'b0;
    for (int k = 0; k < 4 && ((m_fs / BF) % 2 == 0); k++) do_frame(10, 10);
    vga_x = 11'd16; vga_y = 10'd10; valid = 1'b1; color = 24'hABCDEF;
    repeat (3) cycle();
    checks++;
    if (got !== 25'd0) begin errors++; $display("FAIL blink_blank_phase got=%h exp=0", got); end
    blink_en = 1'b0;
    cycle();
    checks++;
    if (got !== 25'd0) begin errors++; $display("FAIL blink_off_1clk got=%h exp=0", got); end
    cycle();
    checks++;
    if (got !== {1'b1, 24'hABCDEF}) begin errors++; $display("FAIL blink_off_2clk got=%h exp=1abcdef", got); end
    valid = 1'b0;
  endtask

  task automatic test_random();
    do_frame(300, 200);
    for (int n = 0; n < 3000; n++) begin
      frame_start = ($urandom_range(0, 199) == 0);
      if (frame_start) begin
        origin_x = 11'($urandom_range(0, 600));
        origin_y = 10'($urandom_range(0, 400));
      end
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_idx  = 3'($urandom_range(0, 7));
      wr_code = 6'(codes[$urandom_range(0, 5)]);
      valid   = ($urandom_range(0, 7) != 0);
      vga_x   = 11'(m_ox - 4 + int'($urandom_range(0, NC*CELL + 8)));
      vga_y   = 10'(m_oy - 3 + int'($urandom_range(0, CELL + 6)));
      if ($urandom_range(0, 63) == 0) invert = ~invert;
      if ($urandom_range(0, 63) == 0) blink_en = ~blink_en;
      color = $urandom;
      cycle();
      checks++;
      if (got !== m_exp) begin errors++; $display("FAIL random n=%0d got=%h exp=%h", n, got, m_exp); end
    end
    frame_start = 1'b0; wr_en = 1'b0; valid = 1'b0; invert = 1'b0; blink_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lit;
    do_write(0, 1);
    do_frame(20, 20);
    color = 24'h00FF00;
    for (int x = 20; x < 36; x++) begin
      vga_x = 11'(x); vga_y = 10'd20; valid = 1'b1;
      reset = (x == 29);
      cycle();
      checks++;
      if (got !== m_exp) begin errors++; $display("FAIL reset_mid x=%0d got=%h exp=%h", x, got, m_exp); end
      if (x == 29) begin
        checks++;
        if (valid_px !== 1'b0) begin errors++; $display("FAIL reset_mid_next got=%b exp=0", valid_px); end
      end
    end
    reset = 1'b0;
    do_frame(20, 20);
    lit = 0;
    for (int y = 20; y < 36; y++) begin
      for (int x = 20; x < 116; x += 3) begin
        vga_x = 11'(x); vga_y = 10'(y); valid = 1'b1;
        cycle();
        lit += int'(valid_px);
        checks++;
        if (got !== m_exp) begin errors++; $display("FAIL after_reset y=%0d x=%0d got=%h exp=%h", y, x, got, m_exp); end
      end
    end
    checks++;
    if (lit !== 0) begin errors++; $display("FAIL after_reset_lit got=%0d exp=0", lit); end
  endtask

  initial begin
    errors = 0; checks = 0;
    model_reset();
    reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_code = '0;
    origin_x = '0; origin_y = '0; blink_en = 1'b0; invert = 1'b0; color = '0;
    vga_x = '0; vga_y = '0; valid = 1'b0;
    test_reset();
    test_blank_scan();
    test_glyph_a();
    test_same_cycle_write();
    test_bad_idx_edge();
    test_blink_invert();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
